cmd_dispatcher: RTL and testbench
=================================

# cmd_dispatcher

Sequences the 8-entry, 96-bit draw-command buffer filled by the instruction compiler out to the OLED SPI byte transmitter. On `start` it reads entries 0..n_cmds-1 in order, expands each into the controller's opcode/argument byte stream, and hands bytes one at a time to the transmitter over a valid/ready handshake. It inserts a programmable settle delay after every command and reports completion. It sits between the command buffer's read port and the SPI byte engine.

## Interface
- WAIT_CYCLES, 100: idle cycles inserted after the last byte of each command (0 = no delay).
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  begin a dispatch run; sampled only in IDLE.
- n_cmds  in  4  entries to dispatch, 0..8; values above 8 clamp to 8; latched on start.
- rd_addr  out  3  command buffer read address.
- rd_data  in  96  buffer read data, valid the cycle after rd_addr is driven (registered read).
- tx_byte  out  8  byte to transmit.
- tx_dc  out  1  data/command select; always 0 (command stream).
- tx_valid  out  1  tx_byte valid.
- tx_ready  in  1  transmitter accepts tx_byte this cycle.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- err  out  1  sticky: an entry had an unsupported opcode; cleared on next accepted start.

## Operation
- Entry layout: [92] fill, [87:80] opcode, [79:48] four coordinate bytes (A=[79:72], B=[71:64], C=[63:56], D=[55:48]), [47:0] six payload bytes (P0=[47:40] .. P5=[7:0]). Bits [95:93], [91:88] ignored.
- Byte stream per opcode:
  - 0x25 clear: 0x25, A, B, C, D (5 bytes).
  - 0x21 line: 0x21, A, B, C, D, P0, P1, P2 (8 bytes).
  - 0x22 rectangle: 0x26, {7'b0, fill}, 0x22, A, B, C, D, P0..P5 (13 bytes).
  - 0x23 copy: 0x23, A, B, C, D, P0, P1 (7 bytes).
  - Any other opcode: no bytes, no WAIT, set err, advance to next entry.
- States: IDLE, FETCH, LOAD, SEND, WAIT, NEXT.
  - IDLE: busy=0. start=1 -> latch clamped n_cmds, clear err, rd_addr<=0. If clamped count is 0, pulse done and stay IDLE; else go to FETCH.
  - FETCH: rd_addr stable; one cycle for the read latency -> LOAD.
  - LOAD: capture rd_data into a 96-bit entry register, decode length, reset byte index to 0. Valid opcode -> SEND; invalid -> set err, go to NEXT.
  - SEND: tx_valid=1, tx_byte=stream[index]. On tx_valid&tx_ready, index+1. After the last byte is accepted, go to WAIT, or to NEXT if WAIT_CYCLES=0.
  - WAIT: count WAIT_CYCLES cycles -> NEXT.
  - NEXT: if this was the last entry, pulse done, go to IDLE. Otherwise rd_addr+1 -> FETCH.
- rd_addr does not wrap: the run ends at entry count-1 and rd_addr is 7 at most.
- tx_byte and tx_valid are registered. Once tx_valid is asserted, tx_byte holds until it is accepted. tx_valid never drops without a handshake, except on reset.

## Timing
- Reset values: rd_addr=0, tx_byte=0, tx_dc=0, tx_valid=0, busy=0, done=0, err=0, state=IDLE, all counters 0.
- busy rises the cycle after start is accepted and falls in the same cycle that done pulses.
- start to first tx_valid: 3 cycles (IDLE->FETCH->LOAD->SEND).
- Throughput with tx_ready held at 1: one byte per cycle inside a command.
- Gap between commands: last accept -> WAIT_CYCLES -> NEXT -> FETCH -> LOAD -> SEND, which is WAIT_CYCLES+4 cycles from the last accept to the next tx_valid.
- Asserting start while busy is ignored and not queued.
- Asserting rst mid-run aborts immediately: tx_valid drops asynchronously, and no done pulse is generated.
- tx_ready stalls of any length are tolerated, and the WAIT count does not start until the last byte is accepted.

## Test plan
- Single clear: n_cmds=1, entry0 opcode 0x25, A..D=00,00,5F,3F, tx_ready=1 -> bytes 25,00,00,5F,3F on consecutive cycles, then WAIT_CYCLES idle, then one done pulse, busy low.
- Filled rectangle: fill=1, opcode 0x22, A..D=10,10,40,20, P0..P5=FF,00,00,FF,00,00 -> 13 bytes starting 26,01,22,10,10,40,20,FF,00,00,FF,00,00. Repeat with fill=0 -> second byte 00.
- Backpressure: line command with tx_ready toggling 1-0-0-1 -> tx_byte is stable during the stalls, exactly 8 handshakes occur, and there are no duplicated or dropped bytes.
- Full buffer with a bad entry: n_cmds=12 (clamped to 8), entry 3 opcode 0x7F -> rd_addr steps 0..7, entry 3 emits no bytes, err=1 at done, and the next start clears err.
- Edge starts: n_cmds=0 -> done pulses the cycle after start with no tx_valid. A start pulsed mid-run is ignored.
- Reset mid-run: assert rst during byte 4 of a rectangle -> all outputs return to reset values at once; a subsequent start replays from entry 0.

Source files
------------

// File: rtl/cmd_dispatcher_if.sv
// ----------------------------------------------------------------------------
// cmd_dispatcher_if
// Bundles the command-buffer read port, the SPI byte handshake and the run
// control/status signals of the command dispatcher.
//   master : the dispatcher (drives rd_addr, tx_*, busy, done, err)
//   slave  : its environment (drives start, n_cmds, rd_data, tx_ready)
// Signals:
//   start/n_cmds     run request and entry count (0..8, larger clamps to 8)
//   rd_addr/rd_data  command buffer read port, data one cycle after address
//   tx_byte/tx_dc    byte to the SPI engine, data/command select (always 0)
//   tx_valid/ready   byte handshake
//   busy/done/err    run status, end-of-run pulse, sticky bad-opcode flag
// ----------------------------------------------------------------------------
interface cmd_dispatcher_if;
    logic        start;
    logic [3:0]  n_cmds;
    logic [2:0]  rd_addr;
    logic [95:0] rd_data;
    logic [7:0]  tx_byte;
    logic        tx_dc;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        input  start, n_cmds, rd_data, tx_ready,
        output rd_addr, tx_byte, tx_dc, tx_valid, busy, done, err
    );

    modport slave (
        output start, n_cmds, rd_data, tx_ready,
        input  rd_addr, tx_byte, tx_dc, tx_valid, busy, done, err
    );
endinterface

// File: rtl/cmd_dispatcher.sv
// ----------------------------------------------------------------------------
// cmd_dispatcher
// Walks entries 0..n-1 of the 8 x 96-bit draw-command buffer, expands each
// entry into the OLED controller opcode/argument byte stream and hands the
// bytes one at a time to the SPI byte transmitter, with WAIT_CYCLES idle
// cycles after every command. Unsupported opcodes emit nothing and set err.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    cmd_dispatcher_if.master (buffer read port, byte handshake, status)
// ----------------------------------------------------------------------------
module cmd_dispatcher #(
    parameter int unsigned WAIT_CYCLES = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    cmd_dispatcher_if.master bus
);

    localparam int unsigned   WW        = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WW-1:0] WAIT_LAST = (WAIT_CYCLES > 0) ? WW'(WAIT_CYCLES - 1) : WW'(0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SEND  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_NEXT  = 3'd5
    } state_t;

    state_t        state_r;
    logic [2:0]    rd_addr_r;
    logic [2:0]    last_r;
    logic [95:0]   entry_r;
    logic [3:0]    len_r;
    logic [3:0]    idx_r;
    logic [WW-1:0] wait_cnt_r;
    logic [7:0]    tx_byte_r;
    logic          tx_valid_r;
    logic          busy_r;
    logic          done_r;
    logic          err_r;

    // Number of bytes emitted for an opcode; 0 marks an unsupported opcode.
    function automatic logic [3:0] stream_len(input logic [7:0] op);
        logic [3:0] len;
        case (op)
            8'h25:   len = 4'd5;
            8'h21:   len = 4'd8;
            8'h22:   len = 4'd13;
            8'h23:   len = 4'd7;
            default: len = 4'd0;
        endcase
        return len;
    endfunction

    // Byte idx of the expanded stream. Bits [79:0] of an entry are the ten
    // argument bytes A..D,P0..P5 in transmit order, so argument byte j is the
    // top byte after shifting left by 8*j. Rectangles are preceded by the
    // fill-mode command (0x26, fill) and their own opcode.
    function automatic logic [7:0] stream_byte(input logic [95:0] e, input logic [3:0] idx);
        logic [7:0]  b;
        logic [79:0] sh;
        b  = 8'h00;
        sh = 80'h0;
        if (e[87:80] == 8'h22) begin
            case (idx)
                4'd0:    b = 8'h26;
                4'd1:    b = {7'b0000000, e[92]};
                4'd2:    b = 8'h22;
                default: begin
                    sh = e[79:0] << {idx - 4'd3, 3'b000};
                    b  = sh[79:72];
                end
            endcase
        end else if (idx == 4'd0) begin
            b = e[87:80];
        end else begin
            sh = e[79:0] << {idx - 4'd1, 3'b000};
            b  = sh[79:72];
        end
        return b;
    endfunction

    // Dispatch sequencer: state, buffer address, byte index, settle counter
    // and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            rd_addr_r  <= 3'd0;
            last_r     <= 3'd0;
            entry_r    <= 96'h0;
            len_r      <= 4'd0;
            idx_r      <= 4'd0;
            wait_cnt_r <= WW'(0);
            tx_byte_r  <= 8'h00;
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        err_r     <= 1'b0;
                        rd_addr_r <= 3'd0;
                        if (bus.n_cmds == 4'd0) begin
                            done_r <= 1'b1;
                        end else begin
                            // last entry index, with counts above 8 clamped to 8
                            last_r  <= (bus.n_cmds >= 4'd8) ? 3'd7 : (bus.n_cmds[2:0] - 3'd1);
                            busy_r  <= 1'b1;
                            state_r <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    state_r <= ST_LOAD;
                end
                ST_LOAD: begin
                    entry_r <= bus.rd_data;
                    len_r   <= stream_len(bus.rd_data[87:80]);
                    idx_r   <= 4'd0;
                    if (stream_len(bus.rd_data[87:80]) == 4'd0) begin
                        err_r   <= 1'b1;
                        state_r <= ST_NEXT;
                    end else begin
                        // first byte comes straight from the read data so that
                        // tx_valid rises together with entering SEND
                        tx_byte_r  <= stream_byte(bus.rd_data, 4'd0);
                        tx_valid_r <= 1'b1;
                        state_r    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (tx_valid_r && bus.tx_ready) begin
                        if (idx_r == len_r - 4'd1) begin
                            tx_valid_r <= 1'b0;
                            wait_cnt_r <= WW'(0);
                            state_r    <= (WAIT_CYCLES == 0) ? ST_NEXT : ST_WAIT;
                        end else begin
                            idx_r     <= idx_r + 4'd1;
                            tx_byte_r <= stream_byte(entry_r, idx_r + 4'd1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_r == WAIT_LAST) begin
                        state_r <= ST_NEXT;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WW'(1);
                    end
                end
                ST_NEXT: begin
                    if (rd_addr_r == last_r) begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        rd_addr_r <= rd_addr_r + 3'd1;
                        state_r   <= ST_FETCH;
                    end
                end
                default: begin
                    tx_valid_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_addr  = rd_addr_r;
    assign bus.tx_byte  = tx_byte_r;
    assign bus.tx_dc    = 1'b0;
    assign bus.tx_valid = tx_valid_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.err      = err_r;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// ----------------------------------------------------------------------------
// tb_cmd_dispatcher
// Randomized and directed stimulus for cmd_dispatcher. A reference model
// expands buffer entries into the expected byte list, sticky error and (with
// tx_ready held high) the expected accept and done cycles.
// ----------------------------------------------------------------------------
module tb_cmd_dispatcher;

    localparam int W = 100;

    typedef logic [7:0] bq_t[$];

    logic clk;
    logic rst_n;
    int   cyc;

    cmd_dispatcher_if bus();

    cmd_dispatcher #(.WAIT_CYCLES(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [95:0] mem [0:7];

    int   n_vec;
    int   n_err;

    bq_t  exp_b;
    int   exp_c[$];
    logic exp_err;
    int   exp_done;

    bq_t  acc_b;
    int   acc_c[$];
    int   done_cnt;
    int   done_c;
    int   max_addr;

    logic       pv;
    logic       pa;
    logic [7:0] pb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cycle counter used for latency checks
    always @(posedge clk) cyc <= cyc + 1;

    // registered buffer read port
    always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // monitor: handshakes, hold-under-stall, done pulses, highest address
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            pv = 1'b0;
        end else begin
            if (pv && !pa) chk("hold", {55'd0, bus.tx_valid, bus.tx_byte}, {55'd0, 1'b1, pb});
            if (bus.tx_valid) chk("tx_dc", {63'd0, bus.tx_dc}, 64'd0);
            if (bus.tx_valid && bus.tx_ready) begin
                acc_b.push_back(bus.tx_byte);
                acc_c.push_back(cyc);
            end
            if (bus.done) begin
                done_cnt++;
                done_c = cyc;
            end
            if (bus.busy && int'(bus.rd_addr) > max_addr) max_addr = int'(bus.rd_addr);
            pv = bus.tx_valid;
            pa = bus.tx_ready;
            pb = bus.tx_byte;
        end
    end

    function automatic logic [95:0] mk(input logic [7:0] op, input logic fill,
                                       input logic [31:0] abcd, input logic [47:0] p);
        logic [95:0] e;
        e = {$urandom, $urandom, $urandom};
        e[92]    = fill;
        e[87:80] = op;
        e[79:48] = abcd;
        e[47:0]  = p;
        return e;
    endfunction

    function automatic logic [95:0] rnd_entry();
        logic [7:0] op;
        int         s;
        s = $urandom_range(0, 9);
        case (s)
            0, 1:    op = 8'h25;
            2, 3:    op = 8'h21;
            4, 5:    op = 8'h22;
            6, 7:    op = 8'h23;
            default: begin
                op = 8'($urandom_range(0, 255));
                if (op == 8'h21 || op == 8'h22 || op == 8'h23 || op == 8'h25) op = 8'h7F;
            end
        endcase
        return mk(op, 1'($urandom), $urandom, {16'($urandom), $urandom});
    endfunction

    // bytes an entry puts on the wire; empty for an unsupported opcode
    function automatic void stream(input logic [95:0] e, output bq_t s);
        logic [7:0] f [10];
        int         nargs;
        for (int k = 0; k < 10; k++) f[k] = e[79 - 8*k -: 8];
        s.delete();
        case (e[87:80])
            8'h25: begin s.push_back(8'h25); nargs = 4; end
            8'h21: begin s.push_back(8'h21); nargs = 7; end
            8'h23: begin s.push_back(8'h23); nargs = 6; end
            8'h22: begin
                s.push_back(8'h26);
                s.push_back({7'd0, e[92]});
                s.push_back(8'h22);
                nargs = 10;
            end
            default: nargs = 0;
        endcase
        for (int k = 0; k < nargs; k++) s.push_back(f[k]);
    endfunction

    // expected bytes, error flag and, for tx_ready held high, cycle numbers:
    // start seen at cycle sc -> first byte offered at sc+3; a valid command
    // takes len cycles plus W settle cycles before its NEXT cycle, a bad one
    // reaches NEXT one cycle after its load; the following command's first
    // byte comes 3 cycles after NEXT and done is visible 1 cycle after NEXT.
    function automatic void build_exp(input int n, input int sc);
        bq_t s;
        int  t;
        int  nx;
        exp_b.delete();
        exp_c.delete();
        exp_err  = 1'b0;
        exp_done = sc + 1;
        t = sc + 3;
        for (int k = 0; k < n; k++) begin
            stream(mem[k], s);
            if (s.size() == 0) begin
                exp_err = 1'b1;
                nx = t;
            end else begin
                for (int j = 0; j < s.size(); j++) begin
                    exp_b.push_back(s[j]);
                    exp_c.push_back(t + j);
                end
                nx = t + s.size() + W;
            end
            if (k == n - 1) exp_done = nx + 1;
            else            t = nx + 3;
        end
    endfunction

    function automatic logic rdy(input int mode, input int i);
        logic [3:0] pat;
        pat = 4'b1001;
        case (mode)
            0:       return 1'b1;
            1:       return 1'($urandom_range(0, 1));
            default: return pat[i % 4];
        endcase
    endfunction

    task automatic run(input int n, input int mode, input bit tchk, input bit inject);
        int clamp;
        int sc;
        bit seen;
        int lim;
        clamp = (n > 8) ? 8 : n;
        @(negedge clk);
        acc_b.delete();
        acc_c.delete();
        done_cnt = 0;
        max_addr = 0;
        sc = cyc;
        build_exp(clamp, sc);
        bus.n_cmds   = 4'(n);
        bus.start    = 1'b1;
        bus.tx_ready = rdy(mode, 0);
        seen = 1'b0;
        for (int i = 1; i < 6000 && !seen; i++) begin
            @(negedge clk);
            bus.start    = (inject && i == 12);
            bus.tx_ready = rdy(mode, i);
            #1;
            if (bus.done) begin
                seen = 1'b1;
                chk("busy_at_done", {63'd0, bus.busy}, 64'd0);
                chk("err_at_done", {63'd0, bus.err}, {63'd0, exp_err});
            end
        end
        if (!seen) chk("done_timeout", 64'd0, 64'd1);
        bus.start    = 1'b0;
        bus.tx_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("done_pulses", 64'(done_cnt), 64'd1);
        chk("busy_after", {63'd0, bus.busy}, 64'd0);
        chk("n_bytes", 64'(acc_b.size()), 64'(exp_b.size()));
        lim = (acc_b.size() < exp_b.size()) ? acc_b.size() : exp_b.size();
        for (int i = 0; i < lim; i++) begin
            chk("byte", {56'd0, acc_b[i]}, {56'd0, exp_b[i]});
            if (tchk) chk("byte_cycle", 64'(acc_c[i] - sc), 64'(exp_c[i] - sc));
        end
        if (tchk && seen) chk("done_cycle", 64'(done_c - sc), 64'(exp_done - sc));
        if (clamp > 0) chk("max_rd_addr", 64'(max_addr), 64'(clamp - 1));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rd_addr"},  {61'd0, bus.rd_addr},  64'd0);
        chk({tag, "_tx_byte"},  {56'd0, bus.tx_byte},  64'd0);
        chk({tag, "_tx_dc"},    {63'd0, bus.tx_dc},    64'd0);
        chk({tag, "_tx_valid"}, {63'd0, bus.tx_valid}, 64'd0);
        chk({tag, "_busy"},     {63'd0, bus.busy},     64'd0);
        chk({tag, "_done"},     {63'd0, bus.done},     64'd0);
        chk({tag, "_err"},      {63'd0, bus.err},      64'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        pv    = 1'b0;
        pa    = 1'b0;
        pb    = 8'h00;
        done_cnt = 0;
        done_c   = 0;
        max_addr = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.n_cmds   = 4'd0;
        bus.tx_ready = 1'b0;
        for (int k = 0; k < 8; k++) mem[k] = rnd_entry();

        repeat (3) @(negedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // single clear, full timing
        mem[0] = mk(8'h25, 1'b0, 32'h00005F3F, 48'h123456789ABC);
        run(1, 0, 1'b1, 1'b0);

        // filled then unfilled rectangle
        mem[0] = mk(8'h22, 1'b1, 32'h10104020, 48'hFF0000FF0000);
        run(1, 0, 1'b1, 1'b0);
        mem[0] = mk(8'h22, 1'b0, 32'h10104020, 48'hFF0000FF0000);
        run(1, 0, 1'b1, 1'b0);

        // line under 1-0-0-1 backpressure
        mem[0] = mk(8'h21, 1'b0, 32'h01020304, 48'hA1B2C3D4E5F6);
        run(1, 2, 1'b0, 1'b0);

        // full buffer, clamped count, bad entry 3, then err clears on restart
        for (int k = 0; k < 8; k++) mem[k] = mk(8'h25, 1'b0, $urandom, 48'h0);
        mem[5] = mk(8'h22, 1'b1, $urandom, {16'($urandom), $urandom});
        mem[3] = mk(8'h7F, 1'b0, $urandom, 48'h0);
        run(12, 1, 1'b0, 1'b0);
        run(1, 0, 1'b1, 1'b0);

        // zero-length run, then a run with a start pulsed mid-run
        run(0, 0, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) mem[k] = rnd_entry();
        run(4, 0, 1'b1, 1'b1);

        // reset while the 4th rectangle byte is on offer, then replay
        mem[0] = mk(8'h22, 1'b1, 32'h10104020, 48'hFF0000FF0000);
        mem[1] = mk(8'h23, 1'b0, 32'hCAFEF00D, 48'h0BADBEEF5566);
        @(negedge clk);
        build_exp(1, cyc);
        bus.n_cmds   = 4'd1;
        bus.start    = 1'b1;
        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("pre_reset_byte", {56'd0, bus.tx_byte}, {56'd0, exp_b[3]});
        chk("pre_reset_valid", {63'd0, bus.tx_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrun");
        @(negedge clk);
        rst_n = 1'b1;
        run(2, 0, 1'b1, 1'b0);

        // randomized runs
        for (int r = 0; r < 16; r++) begin
            int mode;
            for (int k = 0; k < 8; k++) mem[k] = rnd_entry();
            mode = $urandom_range(0, 1);
            run($urandom_range(0, 15), mode, (mode == 0), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
